// File: rtl/filt_buf_reader.sv
// Window reader for the filtered-sample RAM: issues reads, absorbs the one-cycle
// RAM latency and streams samples out through a small credit-controlled FIFO.
module filt_buf_reader #(
    parameter int N  = 256,
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int FD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic [AW-1:0] m_index
);

    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW:0]   len;
    logic [AW-1:0] last_idx;
    logic [AW:0]   issued;
    logic          issue_en;
    logic          vld_p0;
    logic [AW-1:0] idx_p0;
    logic [DW-1:0] fifo_dat [FD];
    logic [AW-1:0] fifo_idx [FD];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          push, pop, fin;

    // A read is only issued when the FIFO is guaranteed a free slot for it,
    // counting the read still travelling through the RAM.
    assign issue_en = (state == RUN) && (issued < len) &&
                      ((int'(fifo_cnt) + int'(vld_p0) + 1) <= FD);
    assign push     = vld_p0;
    assign pop      = m_valid && m_ready;
    assign fin      = pop && m_last;

    assign m_valid  = (fifo_cnt != '0);
    assign m_data   = m_valid ? fifo_dat[rd_ptr] : '0;
    assign m_index  = m_valid ? fifo_idx[rd_ptr] : '0;
    assign m_last   = m_valid && (fifo_idx[rd_ptr] == last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (fin)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    // Stage p0: address accepted by the RAM; data appears on ram_dout next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr <= '0;
            len      <= '0;
            last_idx <= '0;
            issued   <= '0;
            vld_p0   <= 1'b0;
        end else begin
            vld_p0 <= issue_en;
            if (state == IDLE && start) begin
                ram_addr <= base_addr;
                issued   <= '0;
                if (count == '0) begin
                    len      <= (AW+1)'(N);
                    last_idx <= AW'(N - 1);
                end else begin
                    len      <= count;
                    last_idx <= count[AW-1:0] - 1'b1;
                end
            end else if (issue_en) begin
                ram_addr <= ram_addr + 1'b1;
                issued   <= issued + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue_en) idx_p0 <= issued[AW-1:0];
    end

    // Stage p1: RAM output captured into the FIFO together with its ordinal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(FD - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(FD - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dat[wr_ptr] <= ram_dout;
            fifo_idx[wr_ptr] <= idx_p0;
        end
    end

endmodule

// File: tb/tb_filt_buf_reader.sv
// Directed bench for filt_buf_reader with a behavioural one-cycle-latency RAM
// holding RAM[i] = i, so each expected sample equals its RAM address.
module tb_filt_buf_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  count;
    logic        busy, done;
    logic [7:0]  ram_addr;
    logic [31:0] ram_dout;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_data;
    logic [7:0]  m_index;

    logic [31:0] ram [256];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q_data [$];
    int          q_idx  [$];
    bit          q_last [$];
    int          first_vld, done_cyc, done_pulses, stall_viol, max_occ;
    bit          timed_out;
    logic [51:0] rst_snap;

    filt_buf_reader #(.N(256), .AW(8), .DW(32), .FD(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_index(m_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= ram[ram_addr];

    // Starts a window at the current negedge and records beats until one cycle
    // after done (t counts negedges after the start edge, t=0 first).
    task automatic run_window(input logic [7:0] b, input logic [8:0] c, input int mode,
                              input int kick_beat, input bit kick_done, input int rst_beat);
        bit          pv, pr, kicked;
        logic [31:0] pd;
        logic [7:0]  pi;
        logic        pl;
        q_data.delete(); q_idx.delete(); q_last.delete();
        first_vld = -1; done_cyc = -1; done_pulses = 0; stall_viol = 0; max_occ = 0;
        timed_out = 0; kicked = 0; pv = 0; pr = 0; pd = '0; pi = '0; pl = 0;
        base_addr = b; count = c; start = 1'b1;
        m_ready = (mode == 0);
        @(negedge clk);
        for (int t = 0; t < 3000; t++) begin
            if (t > 0) @(negedge clk);
            start = 1'b0;
            if (pv && !pr && (!m_valid || m_data !== pd || m_index !== pi || m_last !== pl))
                stall_viol++;
            if (mode == 0) m_ready = 1'b1;
            else           m_ready = (t >= 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (m_valid && first_vld < 0) first_vld = t;
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = t;
            end
            if (int'(dut.fifo_cnt) > max_occ) max_occ = int'(dut.fifo_cnt);
            if (rst_beat >= 0 && q_data.size() == rst_beat) begin
                rst = 1'b1;
                #1;
                rst_snap = {busy, done, ram_addr, m_valid, m_data, m_last, m_index};
                repeat (3) begin
                    @(negedge clk);
                    if (done) done_pulses++;
                end
                rst = 1'b0;
                return;
            end
            if (kick_beat >= 0 && !kicked && q_data.size() == kick_beat && m_valid) begin
                start = 1'b1; base_addr = 8'd77; count = 9'd3; kicked = 1;
            end
            if (kick_done && done) begin
                start = 1'b1; base_addr = 8'd77; count = 9'd3;
            end
            if (m_valid && m_ready) begin
                q_data.push_back(m_data);
                q_idx.push_back(int'(m_index));
                q_last.push_back(m_last);
            end
            pv = m_valid; pr = m_ready; pd = m_data; pi = m_index; pl = m_last;
            if (done_cyc >= 0 && t == done_cyc + 1) return;
        end
        start = 1'b0;
        timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0; count = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        n_cmp++; if (ram_addr !== 8'd0) begin n_bad++; $display("FAIL reset_ram_addr got=%0d exp=0", ram_addr); end
        n_cmp++; if (m_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        n_cmp++; if (m_data !== 32'd0)  begin n_bad++; $display("FAIL reset_m_data got=%0h exp=0", m_data); end
        n_cmp++; if (m_last !== 1'b0)   begin n_bad++; $display("FAIL reset_m_last got=%0b exp=0", m_last); end
        n_cmp++; if (m_index !== 8'd0)  begin n_bad++; $display("FAIL reset_m_index got=%0d exp=0", m_index); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_window(input logic [8:0] c, input string tag);
        run_window(8'd0, c, 0, -1, 0, -1);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL %s_timeout got=1 exp=0", tag); end
        n_cmp++; if (q_data.size() != 256) begin n_bad++; $display("FAIL %s_beats got=%0d exp=256", tag, q_data.size()); end
        for (int k = 0; k < q_data.size() && k < 256; k++) begin
            n_cmp++;
            if (q_data[k] !== 32'(k) || q_idx[k] != k || q_last[k] !== (k == 255)) begin
                n_bad++;
                $display("FAIL %s_beat%0d got data=%0d idx=%0d last=%0b exp data=%0d idx=%0d last=%0b",
                         tag, k, q_data[k], q_idx[k], q_last[k], k, k, (k == 255));
            end
        end
        n_cmp++; if (first_vld != 2) begin n_bad++; $display("FAIL %s_first_valid got=%0d exp=2", tag, first_vld); end
        n_cmp++; if (done_cyc != 258) begin n_bad++; $display("FAIL %s_done_cycle got=%0d exp=258", tag, done_cyc); end
        n_cmp++; if (done_pulses != 1) begin n_bad++; $display("FAIL %s_done_pulses got=%0d exp=1", tag, done_pulses); end
    endtask

    task automatic test_wrap();
        run_window(8'd200, 9'd100, 0, -1, 0, -1);
        n_cmp++; if (q_data.size() != 100) begin n_bad++; $display("FAIL wrap_beats got=%0d exp=100", q_data.size()); end
        for (int k = 0; k < q_data.size() && k < 100; k++) begin
            n_cmp++;
            if (q_data[k] !== 32'((200 + k) % 256) || q_idx[k] != k || q_last[k] !== (k == 99)) begin
                n_bad++;
                $display("FAIL wrap_beat%0d got data=%0d idx=%0d last=%0b exp data=%0d idx=%0d last=%0b",
                         k, q_data[k], q_idx[k], q_last[k], (200 + k) % 256, k, (k == 99));
            end
        end
        n_cmp++; if (done_cyc != 102) begin n_bad++; $display("FAIL wrap_done_cycle got=%0d exp=102", done_cyc); end
        n_cmp++; if (ram_addr !== 8'd44) begin n_bad++; $display("FAIL wrap_final_addr got=%0d exp=44", ram_addr); end
    endtask

    task automatic test_backpressure();
        run_window(8'd0, 9'd64, 1, -1, 0, -1);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bp_timeout got=1 exp=0"); end
        n_cmp++; if (q_data.size() != 64) begin n_bad++; $display("FAIL bp_beats got=%0d exp=64", q_data.size()); end
        for (int k = 0; k < q_data.size() && k < 64; k++) begin
            n_cmp++;
            if (q_data[k] !== 32'(k) || q_idx[k] != k || q_last[k] !== (k == 63)) begin
                n_bad++;
                $display("FAIL bp_beat%0d got data=%0d idx=%0d last=%0b exp data=%0d idx=%0d last=%0b",
                         k, q_data[k], q_idx[k], q_last[k], k, k, (k == 63));
            end
        end
        n_cmp++; if (stall_viol != 0) begin n_bad++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
        n_cmp++; if (max_occ > 4) begin n_bad++; $display("FAIL bp_fifo_occupancy got=%0d exp<=4", max_occ); end
        n_cmp++; if (max_occ != 4) begin n_bad++; $display("FAIL bp_fifo_fill got=%0d exp=4", max_occ); end
        n_cmp++; if (first_vld != 2) begin n_bad++; $display("FAIL bp_first_valid got=%0d exp=2", first_vld); end
        n_cmp++; if (done_pulses != 1) begin n_bad++; $display("FAIL bp_done_pulses got=%0d exp=1", done_pulses); end
    endtask

    task automatic test_back_to_back();
        run_window(8'd10, 9'd40, 0, 10, 1, -1);
        n_cmp++; if (q_data.size() != 40) begin n_bad++; $display("FAIL b2b_beats got=%0d exp=40", q_data.size()); end
        for (int k = 0; k < q_data.size() && k < 40; k++) begin
            n_cmp++;
            if (q_data[k] !== 32'(10 + k) || q_idx[k] != k) begin
                n_bad++;
                $display("FAIL b2b_beat%0d got data=%0d idx=%0d exp data=%0d idx=%0d", k, q_data[k], q_idx[k], 10 + k, k);
            end
        end
        n_cmp++; if (done_pulses != 1) begin n_bad++; $display("FAIL b2b_done_pulses got=%0d exp=1", done_pulses); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_start_in_done_ignored got busy=%0b exp=0", busy); end
        run_window(8'd30, 9'd5, 0, -1, 0, -1);
        n_cmp++; if (q_data.size() != 5) begin n_bad++; $display("FAIL b2b2_beats got=%0d exp=5", q_data.size()); end
        for (int k = 0; k < q_data.size() && k < 5; k++) begin
            n_cmp++;
            if (q_data[k] !== 32'(30 + k) || q_last[k] !== (k == 4)) begin
                n_bad++;
                $display("FAIL b2b2_beat%0d got data=%0d last=%0b exp data=%0d last=%0b", k, q_data[k], q_last[k], 30 + k, (k == 4));
            end
        end
        n_cmp++; if (first_vld != 2) begin n_bad++; $display("FAIL b2b2_first_valid got=%0d exp=2", first_vld); end
        n_cmp++; if (done_cyc != 7) begin n_bad++; $display("FAIL b2b2_done_cycle got=%0d exp=7", done_cyc); end
    endtask

    task automatic test_rst_mid();
        run_window(8'd0, 9'd0, 0, -1, 0, 50);
        n_cmp++; if (rst_snap !== '0) begin n_bad++; $display("FAIL rstmid_outputs got=%0h exp=0", rst_snap); end
        n_cmp++; if (done_pulses != 0) begin n_bad++; $display("FAIL rstmid_no_done got=%0d exp=0", done_pulses); end
        run_window(8'd5, 9'd1, 0, -1, 0, -1);
        n_cmp++; if (q_data.size() != 1) begin n_bad++; $display("FAIL single_beats got=%0d exp=1", q_data.size()); end
        if (q_data.size() > 0) begin
            n_cmp++;
            if (q_data[0] !== 32'd5 || q_idx[0] != 0 || q_last[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL single_beat got data=%0d idx=%0d last=%0b exp data=5 idx=0 last=1", q_data[0], q_idx[0], q_last[0]);
            end
        end
        n_cmp++; if (done_cyc != 3) begin n_bad++; $display("FAIL single_done_cycle got=%0d exp=3", done_cyc); end
        n_cmp++; if (done_pulses != 1) begin n_bad++; $display("FAIL single_done_pulses got=%0d exp=1", done_pulses); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0; count = '0;
        for (int i = 0; i < 256; i++) ram[i] = 32'(i);
        test_reset();
        test_full_window(9'd0, "full0");
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_rst_mid();
        test_full_window(9'd256, "full256");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
